// File: rtl/ballot_ctrl_if.sv
// Ballot front-end bus: officer/voter inputs toward the sequencer,
// strobes and status back toward the tally datapath and panel.
interface ballot_ctrl_if #(parameter int CNT_W = 8);
  logic             mode;
  logic             arm;
  logic [3:0]       button;
  logic             ready;
  logic             vote_valid;
  logic [1:0]       vote_sel;
  logic             reject;
  logic             busy;
  logic             timeout;
  logic [CNT_W-1:0] ballots_cast;

  modport master (output mode, arm, button,
                  input  ready, vote_valid, vote_sel, reject, busy, timeout, ballots_cast);
  modport slave  (input  mode, arm, button,
                  output ready, vote_valid, vote_sel, reject, busy, timeout, ballots_cast);
endinterface

// File: rtl/ballot_ctrl.sv
// One-vote-per-ballot sequencer: synchronizes buttons, qualifies hold time,
// strobes the tally. Optional armed-ballot expiry under BALLOT_TIMEOUT_EN.
module ballot_ctrl #(
  parameter int NUM_CAND       = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CNT_W          = 8
`ifdef BALLOT_TIMEOUT_EN
  , parameter int ARM_TIMEOUT  = 1000
`endif
) (
  input  logic          clock,
  input  logic          reset,
  ballot_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_QUAL, S_COMMIT, S_WAIT_REL, S_LOCKOUT
  } state_t;

  localparam logic [7:0]          HOLD_C    = 8'(HOLD_CYCLES);
  localparam logic [7:0]          LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [NUM_CAND-1:0] B_ONE     = NUM_CAND'(1);
  localparam logic [CNT_W-1:0]    C_ONE     = CNT_W'(1);

  state_t              state, nstate;
  logic [NUM_CAND-1:0] bs_meta, bs, cap, cap_n;
  logic [7:0]          hcnt, hcnt_n, lcnt, lcnt_n;
  logic [CNT_W-1:0]    cast;
  logic                bs_any, bs_multi, rej, tmo, expire;

  assign bs_any   = |bs;
  assign bs_multi = |(bs & (bs - B_ONE));

`ifdef BALLOT_TIMEOUT_EN
  localparam int          TW   = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ARM_TIMEOUT - 1);
  logic [TW-1:0] tcnt;

  // Held at zero in IDLE so every fresh ballot starts a full window;
  // QUAL time is not counted and does not clear it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 tcnt <= '0;
    else if (state == S_IDLE)   tcnt <= '0;
    else if (state == S_ARMED)  tcnt <= tcnt + TW'(1);
  end
  assign expire = (tcnt == TMAX);
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bs_meta <= '0;
      bs      <= '0;
      state   <= S_IDLE;
      cap     <= '0;
      hcnt    <= '0;
      lcnt    <= '0;
      cast    <= '0;
    end else begin
      bs_meta <= bus.button;
      bs      <= bs_meta;
      state   <= nstate;
      cap     <= cap_n;
      hcnt    <= hcnt_n;
      lcnt    <= lcnt_n;
      if (state == S_COMMIT && cast != '1) cast <= cast + C_ONE;
    end
  end

  always_comb begin
    nstate = state;
    cap_n  = cap;
    hcnt_n = hcnt;
    lcnt_n = lcnt;
    rej    = 1'b0;
    tmo    = 1'b0;
    case (state)
      S_IDLE: if (bus.arm && !bus.mode) nstate = S_ARMED;
      S_ARMED: begin
        if (bus.mode)      nstate = S_IDLE;
        else if (expire) begin
          tmo    = 1'b1;
          nstate = S_IDLE;
        end else if (bs_multi) begin
          rej    = 1'b1;
          nstate = S_WAIT_REL;
        end else if (bs_any) begin
          cap_n  = bs;
          hcnt_n = 8'd1;
          nstate = S_QUAL;
        end
      end
      S_QUAL: begin
        if (bus.mode)      nstate = S_IDLE;
        else if (!bs_any)  nstate = S_ARMED;
        else if (bs_multi) begin
          rej    = 1'b1;
          nstate = S_WAIT_REL;
        end else if (bs == cap) begin
          if (hcnt == HOLD_C) nstate = S_COMMIT;
          else                hcnt_n = hcnt + 8'd1;
        end else begin
          // switched to a different single button: qualify it from scratch
          cap_n  = bs;
          hcnt_n = 8'd1;
        end
      end
      S_COMMIT:   nstate = S_WAIT_REL;
      S_WAIT_REL: if (!bs_any) begin
        lcnt_n = 8'd0;
        nstate = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (bs_any)                 nstate = S_WAIT_REL;
        else if (lcnt == LOCK_LAST) nstate = S_IDLE;
        else                        lcnt_n = lcnt + 8'd1;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    bus.vote_sel = 2'd0;
    if (state == S_COMMIT) begin
      case (cap)
        4'b0010: bus.vote_sel = 2'd1;
        4'b0100: bus.vote_sel = 2'd2;
        4'b1000: bus.vote_sel = 2'd3;
        default: bus.vote_sel = 2'd0;
      endcase
    end
  end

  assign bus.vote_valid   = (state == S_COMMIT);
  assign bus.reject       = rej;
  assign bus.timeout      = tmo;
  assign bus.ready        = (state == S_ARMED) || (state == S_QUAL);
  assign bus.busy         = (state == S_COMMIT) || (state == S_WAIT_REL) || (state == S_LOCKOUT);
  assign bus.ballots_cast = cast;

endmodule
